// File: rtl/mc_sequencer_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer: state encoding,
// exception codes, instruction field constants and the instruction-class enum.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_MDU    = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;
  localparam logic [4:0] EXC_TR  = 5'd13;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_COP0     = 6'h10;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_JALR    = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_BREAK   = 6'h0D;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MTHI    = 6'h11;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MTLO    = 6'h13;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1A;
  localparam logic [5:0] F_DIVU    = 6'h1B;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;
  localparam logic [5:0] F_TEQ     = 6'h34;
  localparam logic [5:0] F2_MUL    = 6'h02;

  localparam logic [4:0]  RS_MFC0  = 5'h00;
  localparam logic [4:0]  RT_BGEZ  = 5'h01;
  localparam logic [25:0] ERET_LOW = 26'h2000018;

  typedef enum logic [3:0] {
    CL_ILLEGAL,
    CL_SYSCALL,
    CL_BREAK,
    CL_JUMP,
    CL_BEQ,
    CL_BNE,
    CL_BGEZ,
    CL_TEQ,
    CL_ERET,
    CL_LOAD,
    CL_STORE,
    CL_MDU,
    CL_MUL,
    CL_HILO,
    CL_ALU
  } instr_class_t;

endpackage

// File: rtl/mc_sequencer_if.sv
// Memory handshake between the sequencer (master) and the memory system (slave).
interface mc_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mc_sequencer_classify.sv
// Combinational instruction classifier: maps the IR to an instruction class and
// the few per-instruction qualifiers the sequencer needs.
module instr_classify
  import ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t iclass,
  output logic         is_store,
  output logic         is_link,
  output logic         is_mul,
  output logic         is_ovf_checked
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];

  always_comb begin
    iclass         = CL_ILLEGAL;
    is_store       = 1'b0;
    is_link        = 1'b0;
    is_mul         = 1'b0;
    is_ovf_checked = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_MFHI, F_MFLO, F_ADDU, F_SUBU, F_AND, F_OR,
          F_XOR, F_NOR, F_SLT, F_SLTU:  iclass = CL_ALU;
          F_ADD, F_SUB: begin
            iclass         = CL_ALU;
            is_ovf_checked = 1'b1;
          end
          F_JR:      iclass = CL_JUMP;
          F_JALR: begin
            iclass  = CL_JUMP;
            is_link = 1'b1;
          end
          F_SYSCALL: iclass = CL_SYSCALL;
          F_BREAK:   iclass = CL_BREAK;
          F_MTHI, F_MTLO: iclass = CL_HILO;
          F_MULT, F_MULTU: begin
            iclass = CL_MDU;
            is_mul = 1'b1;
          end
          F_DIV, F_DIVU: iclass = CL_MDU;
          F_TEQ:     iclass = CL_TEQ;
          default:   iclass = CL_ILLEGAL;
        endcase
      end
      OP_REGIMM: if (rt == RT_BGEZ) iclass = CL_BGEZ;
      OP_J:      iclass = CL_JUMP;
      OP_JAL: begin
        iclass  = CL_JUMP;
        is_link = 1'b1;
      end
      OP_BEQ:    iclass = CL_BEQ;
      OP_BNE:    iclass = CL_BNE;
      OP_ADDI: begin
        iclass         = CL_ALU;
        is_ovf_checked = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        iclass = CL_ALU;
      OP_COP0: begin
        // Only MFC0 and ERET are implemented in coprocessor 0 space.
        if (instr[25:0] == ERET_LOW)
          iclass = CL_ERET;
        else if (rs == RS_MFC0 && instr[10:3] == 8'h00)
          iclass = CL_ALU;
      end
      OP_SPECIAL2: begin
        if (funct == F2_MUL) begin
          iclass = CL_MUL;
          is_mul = 1'b1;
        end
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: iclass = CL_LOAD;
      OP_SB, OP_SH, OP_SW: begin
        iclass   = CL_STORE;
        is_store = 1'b1;
      end
      default: iclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: walks each instruction through fetch, decode,
// execute, memory, write-back, MDU and trap phases and emits Mealy strobes.
module mc_sequencer
  import ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int IRQ_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  mc_sequencer_if.master   mem,
  input  logic [31:0]      instr,
  input  logic             alu_Z,
  input  logic             alu_O,
  input  logic [IRQ_W-1:0] irq,
  input  logic             irq_en,
  output logic             pc_we,
  output logic             ir_we,
  output logic             rf_we,
  output logic             mdu_start,
  output logic             hilo_we,
  output logic             epc_we,
  output logic             exc,
  output logic             eret,
  output logic [4:0]       cause,
  output logic             instr_done,
  output logic [2:0]       state
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       cause_q, cause_d;
  logic             retire;
  logic             mem_req_c, mem_we_c;

  instr_class_t iclass;
  logic         is_store, is_link, is_mul, is_ovf_checked;

  instr_classify u_classify (
    .instr          (instr),
    .iclass         (iclass),
    .is_store       (is_store),
    .is_link        (is_link),
    .is_mul         (is_mul),
    .is_ovf_checked (is_ovf_checked)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    retire     = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    mdu_start  = 1'b0;
    hilo_we    = 1'b0;
    epc_we     = 1'b0;
    exc        = 1'b0;
    eret       = 1'b0;
    cause      = 5'd0;
    instr_done = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (iclass)
          CL_ILLEGAL: begin state_d = ST_TRAP; cause_d = EXC_RI;  end
          CL_SYSCALL: begin state_d = ST_TRAP; cause_d = EXC_SYS; end
          CL_BREAK:   begin state_d = ST_TRAP; cause_d = EXC_BP;  end
          CL_JUMP: begin
            pc_we  = 1'b1;
            rf_we  = is_link;
            retire = 1'b1;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (iclass)
          CL_ALU: begin
            if (is_ovf_checked && alu_O) begin
              state_d = ST_TRAP;
              cause_d = EXC_OV;
            end else begin
              state_d = ST_WB;
            end
          end
          CL_TEQ: begin
            if (alu_Z) begin
              state_d = ST_TRAP;
              cause_d = EXC_TR;
            end else begin
              retire = 1'b1;
            end
          end
          // The datapath compares rs against zero for BGEZ, so Z means "not negative".
          CL_BEQ, CL_BGEZ: begin pc_we = alu_Z;  retire = 1'b1; end
          CL_BNE:          begin pc_we = !alu_Z; retire = 1'b1; end
          CL_ERET: begin
            eret       = 1'b1;
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_MDU, CL_MUL: begin
            mdu_start = 1'b1;
            cnt_d     = is_mul ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
            state_d   = ST_MDU;
          end
          CL_HILO: begin hilo_we = 1'b1; retire = 1'b1; end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = is_store;
        if (mem.mem_ready) begin
          if (is_store) retire  = 1'b1;
          else          state_d = ST_WB;
        end
      end
      ST_MDU: begin
        if (cnt_q == '0) begin
          if (iclass == CL_MUL) begin
            state_d = ST_WB;
          end else begin
            hilo_we = 1'b1;
            retire  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      ST_TRAP: begin
        exc     = 1'b1;
        epc_we  = 1'b1;
        pc_we   = 1'b1;
        cause   = cause_q;
        state_d = ST_FETCH;
      end
    endcase

    // Interrupts are only sampled at a retire boundary, which keeps them precise.
    if (retire) begin
      instr_done = 1'b1;
      if (irq_en && (|irq)) begin
        state_d = ST_TRAP;
        cause_d = EXC_INT;
      end else begin
        state_d = ST_FETCH;
      end
    end

    if (!reset) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      rf_we      = 1'b0;
      mem_req_c  = 1'b0;
      mem_we_c   = 1'b0;
      mdu_start  = 1'b0;
      hilo_we    = 1'b0;
      epc_we     = 1'b0;
      exc        = 1'b0;
      eret       = 1'b0;
      cause      = 5'd0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cause_q <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign state       = state_q;

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Parametrised multicycle control sequencer for the 54-instruction MIPS core. It takes the fetched instruction and datapath flags and steps each instruction through fetch, decode, execute, memory, write-back, multi-cycle MDU and trap phases. Per phase it emits register-enable strobes. Compared with the flat decode controller it adds a memory handshake, configurable MDU latencies, and precise exception/interrupt entry.

## Interface
- `MUL_CYCLES`, default 4: MULT/MULTU/MUL busy cycles, ≥1.
- `DIV_CYCLES`, default 33: DIV/DIVU busy cycles, ≥1.
- `IRQ_W`, default 6: number of interrupt lines.
- `clk`, in, 1: clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `instr`, in, 32: IR contents, stable from DECODE until retire.
- `mem_ready`, in, 1: memory acknowledge for the current `mem_req`.
- `alu_Z`, in, 1: ALU zero flag.
- `alu_O`, in, 1: ALU signed-overflow flag.
- `irq`, in, IRQ_W: level interrupt requests.
- `irq_en`, in, 1: Status.IE.
- `pc_we`, out, 1: PC load.
- `ir_we`, out, 1: IR load.
- `rf_we`, out, 1: register-file write.
- `mem_req`, out, 1: memory request.
- `mem_we`, out, 1: store qualifier for `mem_req`.
- `mdu_start`, out, 1: one-cycle MDU launch.
- `hilo_we`, out, 1: HI/LO write.
- `epc_we`, out, 1: EPC capture.
- `exc`, out, 1: exception entry.
- `eret`, out, 1: ERET return.
- `cause`, out, 5: ExcCode, valid with `exc`.
- `instr_done`, out, 1: retire pulse.
- `state`, out, 3: current state, for debug.

## Operation
- States:
  - IDLE=0
  - FETCH=1
  - DECODE=2
  - EXEC=3
  - MEM=4
  - WB=5
  - MDU=6
  - TRAP=7
- Reset:
  - State goes to IDLE and the MDU counter to 0.
  - While in IDLE, all outputs are 0 and `cause` is 0.
  - IDLE goes to FETCH unconditionally on the next edge.
- FETCH:
  - `mem_req`=1, `mem_we`=0, held until `mem_ready`=1.
  - In the `mem_ready` cycle, `ir_we`=1 and `pc_we`=1 (PC+4), then go to DECODE.
- DECODE, in this priority order:
  1. Unrecognised instruction: go to TRAP, cause 10.
  2. SYSCALL: go to TRAP, cause 8.
  3. BREAK: go to TRAP, cause 9.
  4. J/JAL/JR/JALR: `pc_we`=1. JAL/JALR also assert `rf_we`=1. Retire.
  5. All others: go to EXEC.
- EXEC:
  - ADD/ADDI/SUB with `alu_O`=1: go to TRAP, cause 12. No `rf_we`.
  - TEQ with `alu_Z`=1: go to TRAP, cause 13. TEQ with `alu_Z`=0 retires.
  - BEQ/BNE/BGEZ: `pc_we`=1 if taken, then retire.
  - ERET: `eret`=1 and `pc_we`=1, then retire. Interrupts are not checked on this retire.
  - Load or store: go to MEM.
  - MULT/MULTU/MUL/DIV/DIVU:
    - `mdu_start`=1.
    - Counter is loaded with `MUL_CYCLES`-1 (multiplies) or `DIV_CYCLES`-1 (divides).
    - Go to MDU.
  - MTHI/MTLO: `hilo_we`=1, then retire.
  - Everything else: go to WB.
- MEM:
  - `mem_req`=1, `mem_we`=store, held until `mem_ready`.
  - On `mem_ready`, a store retires and a load goes to WB.
- MDU:
  - Counter decrements each cycle.
  - When the counter is 0:
    - `hilo_we`=1 for MULT/MULTU/DIV/DIVU, then retire.
    - MUL goes to WB instead.
  - With a latency of 1, MDU lasts exactly one cycle.
- WB: `rf_we`=1, then retire.
- TRAP: for one cycle, `exc`=1, `epc_we`=1, `pc_we`=1 (vector) and `cause` is valid; then go to FETCH. TRAP does not pulse `instr_done`.
- Retire:
  - `instr_done`=1.
  - Interrupt check: if `irq_en` and any `irq` bit is set, go to TRAP with cause 0.
  - Otherwise go to FETCH.
- Simultaneous events:
  - A synchronous exception in the same cycle as a pending interrupt: the exception is taken, and the interrupt is re-evaluated at the next retire.
  - `mem_ready` while `mem_req`=0 is ignored.
  - `irq` changing mid-instruction has no effect until retire.

## Timing
- Mealy outputs: all strobes are combinational from state, `instr`, flags and `mem_ready`.
- Registers: only the state, the MDU counter and the latched cause are registered.
- Cycles per instruction with zero-wait memory (`mem_ready` high in the first cycle):

| Instruction class | Cycles |
|---|---|
| Jump | 2 |
| Branch, ALU no-WB | 3 |
| ALU with WB | 4 |
| Store | 4 |
| Load | 5 |
| MULT/MULTU/DIV/DIVU | 3 + latency |
| MUL | 4 + latency |
| Trap entry | +1 |

- Each memory wait cycle adds 1.
- Reset assertion mid-instruction aborts immediately. No strobe may be asserted while `reset`=0.
- MDU counter width: `$clog2(max(MUL_CYCLES, DIV_CYCLES))`, minimum 1.

## Structure
- Shared package `ctrl_pkg` holds:
  - state encoding
  - ExcCode constants (0, 8, 9, 10, 12, 13)
  - opcode/funct/rs constants
  - instruction-class enum
- Sub-module `instr_classify` is purely combinational. It maps `instr` to a class, plus `is_store`, `is_link`, `is_mul` and `is_ovf_checked` flags.

## Test plan
- Reset, then ADDU with `mem_ready` tied high: states 0→1→2→3→5→1, `rf_we` in cycle 4, `instr_done` in cycle 4.
- LW with `mem_ready` low for 3 MEM cycles: `mem_req` high for 4 cycles, `mem_we`=0, `rf_we` exactly 1 cycle after the ack.
- DIV with DIV_CYCLES=33: `mdu_start` pulses once, then 33 MDU cycles, `hilo_we` in the last one, `rf_we` never asserted.
- ADD with `alu_O`=1 and `irq`=1, `irq_en`=1: TRAP with `cause`=12 and no `rf_we`. The next retire traps with `cause`=0.
- TEQ with `alu_Z`=1: TRAP `cause`=13. SYSCALL gives `cause`=8 directly from DECODE. An unknown opcode (0x3F) gives `cause`=10.
- Reset pulled low during MDU: outputs go to 0 immediately. After release: IDLE, then FETCH with the counter at 0.
